cc_refill_deserializer: RTL and testbench

CC_REFILL_DESERIALIZER -- requirements
Module: cc_refill_deserializer

---
 rtl/cc_pkg.sv | 18 +
 rtl/cc_refill_deserializer.sv | 142 ++++++++++++++
 tb/tb_cc_refill_deserializer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared cache-refill types and widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_pkg;

    localparam int CC_WORD_W     = 64;
    localparam int CC_LINE_WORDS = 8;
    localparam int CC_LINE_W     = 512;
    localparam int CC_ADDR_W     = 32;
    localparam int CC_PTR_W      = 3;

    // Collect FSM: waiting for a miss, or gathering the beats of one line.
    typedef enum logic {
        CC_IDLE    = 1'b0,
        CC_COLLECT = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_refill_deserializer.sv
// Snoops the memory R channel and assembles wrap-ordered beats into a full cache line.
// Latency: fill_valid_o rises 1 cycle after the eighth beat handshake.
// Backpressure: never stalls R; a completed line is dropped (error_o) if the fill buffer cannot retire.
module cc_refill_deserializer
    import cc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_req_valid_i,
    output logic                 miss_req_ready_o,
    input  logic [CC_ADDR_W-1:0] miss_req_addr_i,
    input  logic [CC_WORD_W-1:0] mem_rdata_i,
    input  logic                 mem_rlast_i,
    input  logic                 mem_rvalid_i,
    input  logic                 mem_rready_i,
    output logic                 fill_valid_o,
    input  logic                 fill_ready_i,
    output logic [CC_ADDR_W-1:0] fill_addr_o,
    output logic [CC_LINE_W-1:0] fill_data_o,
    output logic                 error_o
);

    cc_state_e             state_q, state_d;
    logic [CC_PTR_W-1:0]   ptr_q, ptr_d;
    logic [CC_PTR_W-1:0]   cnt_q, cnt_d;
    logic [CC_ADDR_W-1:0]  addr_q, addr_d;
    logic [CC_LINE_W-1:0]  asm_q, asm_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [CC_ADDR_W-1:0]  fill_addr_q, fill_addr_d;
    logic [CC_LINE_W-1:0]  fill_data_q, fill_data_d;
    logic                  error_q, error_d;

    logic                  beat;
    logic                  line_done;
    logic [CC_LINE_W-1:0]  line_next;

    // Byte offset within a word never matters; only [5:3] selects the critical word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^miss_req_addr_i[2:0];

    // The R channel is only observed: a beat is whatever the reorder path accepts.
    assign beat = mem_rvalid_i & mem_rready_i;

    // Next-state: collect FSM, assembly buffer, and the double-buffered fill output.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        asm_d        = asm_q;
        fill_valid_d = fill_valid_q;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        error_d      = 1'b0;
        line_done    = 1'b0;

        // Assembly buffer with the current beat merged in, so the eighth beat
        // can go straight into the output register on its own handshake edge.
        line_next = asm_q;
        line_next[32'(ptr_q) * CC_WORD_W +: CC_WORD_W] = mem_rdata_i;

        case (state_q)
            CC_IDLE: begin
                // A beat with no line outstanding is a protocol violation.
                if (beat) begin
                    error_d = 1'b1;
                end
                if (miss_req_valid_i) begin
                    state_d = CC_COLLECT;
                    addr_d  = {miss_req_addr_i[CC_ADDR_W-1:6], 6'b0};
                    ptr_d   = miss_req_addr_i[5:3];
                    cnt_d   = '0;
                end
            end
            CC_COLLECT: begin
                if (beat) begin
                    asm_d = line_next;
                    ptr_d = ptr_q + 3'd1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = CC_IDLE;
                        if (mem_rlast_i) begin
                            line_done = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (mem_rlast_i) begin
                        state_d = CC_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = CC_IDLE;
        endcase

        // Output buffer: a new line may replace the pending one only if the
        // pending one retires on the same edge; otherwise the new line is lost.
        if (line_done) begin
            if (!fill_valid_q || fill_ready_i) begin
                fill_valid_d = 1'b1;
                fill_data_d  = line_next;
                fill_addr_d  = addr_q;
            end else begin
                error_d = 1'b1;
            end
        end else if (fill_valid_q && fill_ready_i) begin
            fill_valid_d = 1'b0;
        end
    end

    // All state registers; reset abandons any partial line silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CC_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            asm_q        <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            asm_q        <= asm_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
            error_q      <= error_d;
        end
    end

    assign miss_req_ready_o = (state_q == CC_IDLE);
    assign fill_valid_o     = fill_valid_q;
    assign fill_addr_o      = fill_addr_q;
    assign fill_data_o      = fill_data_q;
    assign error_o          = error_q;

endmodule

// File: tb/tb_cc_refill_deserializer.sv
// Bench for cc_refill_deserializer: vector table, corner-case sequences, random traffic vs a line-level model.
module tb_cc_refill_deserializer;
    import cc_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 miss_req_valid_i = 1'b0;
    logic                 miss_req_ready_o;
    logic [CC_ADDR_W-1:0] miss_req_addr_i = '0;
    logic [CC_WORD_W-1:0] mem_rdata_i = '0;
    logic                 mem_rlast_i = 1'b0;
    logic                 mem_rvalid_i = 1'b0;
    logic                 mem_rready_i = 1'b0;
    logic                 fill_valid_o;
    logic                 fill_ready_i = 1'b0;
    logic [CC_ADDR_W-1:0] fill_addr_o;
    logic [CC_LINE_W-1:0] fill_data_o;
    logic                 error_o;

    cc_refill_deserializer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_req_valid_i (miss_req_valid_i),
        .miss_req_ready_o (miss_req_ready_o),
        .miss_req_addr_i  (miss_req_addr_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_rlast_i      (mem_rlast_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rready_i     (mem_rready_i),
        .fill_valid_o     (fill_valid_o),
        .fill_ready_i     (fill_ready_i),
        .fill_addr_o      (fill_addr_o),
        .fill_data_o      (fill_data_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model (line-level) ----------------
    bit                   m_collect;
    int                   m_start;
    int                   m_n;
    logic [CC_ADDR_W-1:0] m_base;
    logic [CC_WORD_W-1:0] m_words [CC_LINE_WORDS];
    bit                   m_fv;
    logic [CC_ADDR_W-1:0] m_faddr;
    logic [CC_LINE_W-1:0] m_fdata;
    bit                   m_err;

    task automatic model_reset();
        m_collect = 0; m_start = 0; m_n = 0; m_base = '0;
        m_fv = 0; m_faddr = '0; m_fdata = '0; m_err = 0;
        for (int w = 0; w < CC_LINE_WORDS; w++) m_words[w] = '0;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_update();
        bit b;
        bit retire;
        bit done;
        b      = mem_rvalid_i && mem_rready_i;
        retire = m_fv && fill_ready_i;
        done   = 0;
        m_err  = 0;
        if (!m_collect) begin
            if (b) m_err = 1;
            if (miss_req_valid_i) begin
                m_collect = 1;
                m_base    = {miss_req_addr_i[31:6], 6'b0};
                m_start   = int'(miss_req_addr_i[5:3]);
                m_n       = 0;
            end
        end else if (b) begin
            m_words[(m_start + m_n) % 8] = mem_rdata_i;
            m_n++;
            if (m_n == 8 && mem_rlast_i) begin
                done = 1;
                m_collect = 0;
            end else if (m_n == 8 || mem_rlast_i) begin
                m_err = 1;
                m_collect = 0;
            end
        end
        if (done) begin
            if (!m_fv || fill_ready_i) begin
                m_fv = 1;
                m_faddr = m_base;
                for (int w = 0; w < CC_LINE_WORDS; w++) m_fdata[w*64 +: 64] = m_words[w];
            end else begin
                m_err = 1;
            end
        end else if (retire) begin
            m_fv = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [CC_LINE_W-1:0] got, input logic [CC_LINE_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_ready", miss_req_ready_o, !m_collect);
        chk("m_fill_valid", fill_valid_o, m_fv);
        chk("m_error", error_o, m_err);
        chk("m_fill_addr", fill_addr_o, m_faddr);
        chk("m_fill_data", fill_data_o, m_fdata);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic quiet();
        miss_req_valid_i = 0; mem_rvalid_i = 0; mem_rready_i = 0; mem_rlast_i = 0;
    endtask

    // Expected line for a request at addr whose k-th beat carries base+k.
    function automatic logic [CC_LINE_W-1:0] line_exp(input logic [31:0] addr, input logic [63:0] base);
        logic [CC_LINE_W-1:0] l;
        int s;
        l = '0;
        s = int'(addr[5:3]);
        for (int k = 0; k < 8; k++) l[((s + k) % 8) * 64 +: 64] = base + 64'(k);
        return l;
    endfunction

    // Request plus eight back-to-back beats; fill_ready only on the last beat if asked.
    task automatic send_line(input logic [31:0] addr, input logic [63:0] base, input bit fr_last);
        miss_req_valid_i = 1; miss_req_addr_i = addr;
        step();
        quiet();
        for (int k = 0; k < 8; k++) begin
            mem_rvalid_i = 1; mem_rready_i = 1; mem_rlast_i = (k == 7);
            mem_rdata_i = base + 64'(k);
            fill_ready_i = fr_last && (k == 7);
            step();
        end
        quiet();
        fill_ready_i = 0;
    endtask

    typedef struct packed {
        logic        req_v;
        logic [31:0] addr;
        logic        rv, rr, rl;
        logic [63:0] d;
        logic        fr;
        logic        e_rdy, e_fv, e_err;
    } vec_t;

    vec_t tbl [$];
    logic [CC_LINE_W-1:0] exp_line;

    initial begin
        model_reset();
        // Reset state
        #12;
        chk("rst_ready", miss_req_ready_o, 1'b1);
        chk("rst_fill_valid", fill_valid_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_fill_addr", fill_addr_o, 32'h0);
        chk("rst_fill_data", fill_data_o, '0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Critical word 5, eight back-to-back beats, then retire.
        tbl.push_back('{1'b1, 32'h0000_1028, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b1, (i == 7), 64'hD000_0000_0000_0000 | 64'(i), 1'b0,
                            (i == 7), (i == 7), 1'b0});
        tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            miss_req_valid_i = tbl[i].req_v; miss_req_addr_i = tbl[i].addr;
            mem_rvalid_i = tbl[i].rv; mem_rready_i = tbl[i].rr; mem_rlast_i = tbl[i].rl;
            mem_rdata_i = tbl[i].d; fill_ready_i = tbl[i].fr;
            step();
            chk("tbl_ready", miss_req_ready_o, tbl[i].e_rdy);
            chk("tbl_fill_valid", fill_valid_o, tbl[i].e_fv);
            chk("tbl_error", error_o, tbl[i].e_err);
            if (i == 9) begin
                exp_line = '0;
                for (int k = 0; k < 8; k++)
                    exp_line[((5 + k) % 8) * 64 +: 64] = 64'hD000_0000_0000_0000 | 64'(k);
                chk("wrap5_addr", fill_addr_o, 32'h0000_1000);
                chk("wrap5_data", fill_data_o, exp_line);
            end
        end
        quiet(); fill_ready_i = 0;

        // rready toggling: only handshaked beats are stored.
        miss_req_valid_i = 1; miss_req_addr_i = 32'h0000_2000;
        step();
        quiet();
        for (int k = 0; k < 16; k++) begin
            mem_rvalid_i = 1; mem_rready_i = (k % 2 == 0); mem_rlast_i = (k == 14);
            mem_rdata_i = 64'hA0 + 64'(k);
            step();
            if (k == 13) chk("toggle_no_early_fill", fill_valid_o, 1'b0);
            if (k == 14) chk("toggle_fill_after_8th", fill_valid_o, 1'b1);
        end
        quiet();
        exp_line = '0;
        for (int w = 0; w < 8; w++) exp_line[w*64 +: 64] = 64'hA0 + 64'(2 * w);
        chk("toggle_data", fill_data_o, exp_line);
        fill_ready_i = 1; step(); fill_ready_i = 0;

        // rlast on the fourth beat.
        miss_req_valid_i = 1; miss_req_addr_i = 32'h0000_3010;
        step();
        quiet();
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1; mem_rready_i = 1; mem_rlast_i = (k == 3); mem_rdata_i = 64'h55 + 64'(k);
            step();
        end
        chk("early_last_err", error_o, 1'b1);
        chk("early_last_no_fill", fill_valid_o, 1'b0);
        quiet();
        step();
        chk("early_last_err_pulse", error_o, 1'b0);
        chk("early_last_ready", miss_req_ready_o, 1'b1);
        chk("early_last_still_no_fill", fill_valid_o, 1'b0);

        // Overflow while pending, then replacement with same-cycle retire.
        send_line(32'h0000_4008, 64'h4400, 1'b0);
        send_line(32'h0000_5030, 64'h5500, 1'b0);
        chk("ovf_err", error_o, 1'b1);
        chk("ovf_fv_held", fill_valid_o, 1'b1);
        chk("ovf_data_kept", fill_data_o, line_exp(32'h0000_4008, 64'h4400));
        chk("ovf_addr_kept", fill_addr_o, 32'h0000_4000);
        send_line(32'h0000_6018, 64'h6600, 1'b1);
        chk("swap_fv", fill_valid_o, 1'b1);
        chk("swap_err", error_o, 1'b0);
        chk("swap_data", fill_data_o, line_exp(32'h0000_6018, 64'h6600));
        chk("swap_addr", fill_addr_o, 32'h0000_6000);

        // Reset after the third beat of a line.
        miss_req_valid_i = 1; miss_req_addr_i = 32'h0000_7000;
        step();
        quiet();
        for (int k = 0; k < 3; k++) begin
            mem_rvalid_i = 1; mem_rready_i = 1; mem_rdata_i = 64'h77 + 64'(k);
            step();
        end
        quiet();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_fv", fill_valid_o, 1'b0);
        chk("midrst_err", error_o, 1'b0);
        chk("midrst_ready", miss_req_ready_o, 1'b1);
        #2 rst_n = 1'b1;
        send_line(32'h0000_8038, 64'h8800, 1'b0);
        chk("postrst_fv", fill_valid_o, 1'b1);
        chk("postrst_err", error_o, 1'b0);
        chk("postrst_data", fill_data_o, line_exp(32'h0000_8038, 64'h8800));
        fill_ready_i = 1; step(); fill_ready_i = 0;

        // Beat while idle.
        mem_rvalid_i = 1; mem_rready_i = 1; mem_rdata_i = 64'hBAD;
        step();
        chk("idle_beat_err", error_o, 1'b1);
        chk("idle_beat_ready", miss_req_ready_o, 1'b1);
        quiet();
        step();
        chk("idle_beat_err_pulse", error_o, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            miss_req_valid_i = ($urandom % 4 == 0);
            miss_req_addr_i  = $urandom;
            mem_rvalid_i     = m_collect ? ($urandom % 4 != 0) : ($urandom % 20 == 0);
            mem_rready_i     = ($urandom % 3 != 0);
            mem_rlast_i      = (m_collect && m_n == 7) ? ($urandom % 16 != 0) : ($urandom % 40 == 0);
            mem_rdata_i      = {$urandom, $urandom};
            fill_ready_i     = ($urandom % 3 == 0);
            step();
        end
        quiet(); fill_ready_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
